// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit five-stage pipeline: widths, opcodes,
// NOP encoding and the fetch-stage state type.
package cpu_pkg;

   localparam int INSTR_W = 16;
   localparam int ADDR_W  = 16;

   localparam logic [3:0] OPC_B    = 4'hC;
   localparam logic [3:0] OPC_CALL = 4'hD;
   localparam logic [3:0] OPC_RET  = 4'hE;
   localparam logic [3:0] OPC_HLT  = 4'hF;

   localparam logic [INSTR_W-1:0] NOP_ENC = 16'h0000;

   typedef enum logic {
      FS_RUN  = 1'b0,
      FS_HALT = 1'b1
   } fetch_state_e;

   function automatic logic [3:0] opcode_of(input logic [INSTR_W-1:0] instr);
      return instr[INSTR_W-1:INSTR_W-4];
   endfunction

endpackage

// File: rtl/ifid_reg.sv
// Generic stage register carrying an instruction, its PC+1 and a valid bit.
// Bubble beats hold so a squash always lands even while the pipe is frozen.
module ifid_reg
   import cpu_pkg::*;
#(
   parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_ENC
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_hold,
   input  logic               i_bubble,
   input  logic [INSTR_W-1:0] i_instr,
   input  logic [ADDR_W-1:0]  i_pc_plus1,
   output logic [INSTR_W-1:0] o_instr,
   output logic [ADDR_W-1:0]  o_pc_plus1,
   output logic               o_vld
);

   logic [INSTR_W-1:0] r_instr_p1;
   logic [ADDR_W-1:0]  r_pc_plus1_p1;
   logic               r_vld_p1;

   // stage boundary: fetch -> decode
   always_ff @(posedge clk) begin
      if (rst) begin
         r_instr_p1    <= NOP_INSTR;
         r_pc_plus1_p1 <= '0;
         r_vld_p1      <= 1'b0;
      end else if (i_bubble) begin
         r_instr_p1    <= NOP_INSTR;
         r_vld_p1      <= 1'b0;
      end else if (!i_hold) begin
         r_instr_p1    <= i_instr;
         r_pc_plus1_p1 <= i_pc_plus1;
         r_vld_p1      <= 1'b1;
      end
   end

   assign o_instr    = r_instr_p1;
   assign o_pc_plus1 = r_pc_plus1_p1;
   assign o_vld      = r_vld_p1;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC and the RUN/HALT state, issues instruction-memory
// requests and feeds the IF/ID register with fetched words or bubbles.
module instr_fetch
   import cpu_pkg::*;
#(
   parameter logic [ADDR_W-1:0]  RESET_PC  = 16'h0000,
   parameter logic [INSTR_W-1:0] NOP_INSTR = 16'h0000,
   parameter logic [3:0]         HLT_OPC   = 4'hF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               stall,
   input  logic               redirect_vld,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic [ADDR_W-1:0]  im_addr,
   output logic               im_rd_en,
   input  logic [INSTR_W-1:0] im_instr,
   input  logic               im_rdy,
   output logic [INSTR_W-1:0] ifid_instr,
   output logic [ADDR_W-1:0]  ifid_pc_plus1,
   output logic               ifid_vld,
   output logic               halted,
   output logic [15:0]        fetch_cnt
);

   fetch_state_e      r_state;
   fetch_state_e      w_state_nxt;
   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] w_pc_nxt;
   logic [ADDR_W-1:0] w_pc_plus1;
   logic [15:0]       r_cnt;
   logic [15:0]       w_cnt_nxt;
   logic              w_deliver;
   logic              w_is_hlt;
   logic              w_ifid_hold;
   logic              w_ifid_bubble;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   assign w_pc_plus1 = r_pc + 16'd1;
   assign w_is_hlt   = (opcode_of(im_instr) == HLT_OPC);

   // A real instruction enters IF/ID only when nothing higher-priority intervenes.
   assign w_deliver     = !redirect_vld && !stall && (r_state == FS_RUN) && im_rdy;
   assign w_ifid_hold   = stall && !redirect_vld;
   assign w_ifid_bubble = redirect_vld || (!stall && !w_deliver);

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_cnt_nxt   = r_cnt;
      if (redirect_vld) begin
         w_pc_nxt    = redirect_pc;
         w_state_nxt = FS_RUN;
      end else if (w_deliver) begin
         w_cnt_nxt = sat_inc16(r_cnt);
         if (w_is_hlt) begin
            w_state_nxt = FS_HALT;
         end else begin
            w_pc_nxt = w_pc_plus1;
         end
      end
   end

   // stage boundary: PC / fetch-state registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= FS_RUN;
         r_pc    <= RESET_PC;
         r_cnt   <= 16'h0000;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   ifid_reg #(
      .NOP_INSTR (NOP_INSTR)
   ) u_ifid_reg (
      .clk        (clk),
      .rst        (rst),
      .i_hold     (w_ifid_hold),
      .i_bubble   (w_ifid_bubble),
      .i_instr    (im_instr),
      .i_pc_plus1 (w_pc_plus1),
      .o_instr    (ifid_instr),
      .o_pc_plus1 (ifid_pc_plus1),
      .o_vld      (ifid_vld)
   );

   assign im_addr   = r_pc;
   assign im_rd_en  = (r_state == FS_RUN) && !rst && !stall;
   assign halted    = (r_state == FS_HALT);
   assign fetch_cnt = r_cnt;

endmodule
